// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The EX decode uses the same operation codes.
package muldiv_unit_pkg;
  localparam logic [1:0] MDU_OP_MULTU = 2'b00;
  localparam logic [1:0] MDU_OP_MULT  = 2'b01;
  localparam logic [1:0] MDU_OP_DIVU  = 2'b10;
  localparam logic [1:0] MDU_OP_DIV   = 2'b11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift in a dividend bit and try to subtract the divisor.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic             o_q
);
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {2'b00, i_div};
  // A borrow out of the top bit means the trial subtraction went negative.
  assign o_q     = ~w_diff[WIDTH+1];
  assign o_rem   = o_q ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: magnitudes are processed one bit per cycle,
// signs are applied in a single FIX cycle afterwards.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);
  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic               r_neg_res, r_neg_rem;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb, r_quo;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_dbz;

  logic               w_is_div, w_na, w_nb, w_last, w_q;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo_f, w_rem_f;
  logic [WIDTH:0]     w_sum, w_rem_nxt;
  logic [2*WIDTH-1:0] w_prod;

  assign w_is_div = op_i[1];
  assign w_na     = op_i[0] & opa_i[WIDTH-1];
  assign w_nb     = op_i[0] & opb_i[WIDTH-1];
  assign w_abs_a  = w_na ? -opa_i : opa_i;
  assign w_abs_b  = w_nb ? -opb_i : opb_i;
  assign w_last   = (r_cnt == CNT_W'(WIDTH-1));

  // Multiplier sits in the low half of the accumulator and shifts out as the product shifts in.
  assign w_sum = r_acc[0] ? ({1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb})
                          : {1'b0, r_acc[2*WIDTH-1:WIDTH]};

  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_bit (r_quo[WIDTH-1]),
    .i_div (r_opb),
    .o_rem (w_rem_nxt),
    .o_q   (w_q)
  );

  assign w_prod  = (r_op[0] & r_neg_res) ? -r_acc : r_acc;
  assign w_quo_f = (r_op[0] & r_neg_res) ? -r_quo : r_quo;
  assign w_rem_f = (r_op[0] & r_neg_rem) ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz     <= 1'b0;
    end else if (annul_i && r_state != S_IDLE) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start_i && !annul_i) begin
          r_op      <= op_i;
          r_cnt     <= '0;
          r_neg_res <= w_na ^ w_nb;
          r_neg_rem <= w_na;
          r_acc     <= {{WIDTH{1'b0}}, w_abs_b};
          r_opb     <= w_is_div ? w_abs_b : w_abs_a;
          r_quo     <= w_abs_a;
          r_rem     <= '0;
          r_dbz     <= 1'b0;
          if (w_is_div && opb_i == '0) begin
            r_hi    <= opa_i;
            r_lo    <= '1;
            r_dbz   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= w_is_div ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          r_acc <= {w_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= S_FIX;
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= {r_quo[WIDTH-2:0], w_q};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_op[1]) begin
            r_lo <= w_quo_f;
            r_hi <= w_rem_f;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
  assign ready_o       = (r_state == S_DONE);
  assign hi_o          = r_hi;
  assign lo_o          = r_lo;
  assign div_by_zero_o = r_dbz;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32: expectations queued at start, checked on ready_o.
module tb_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic [W-1:0]  opa_i = '0, opb_i = '0;
  logic          annul_i = 1'b0;
  logic          busy_o, ready_o, div_by_zero_o;
  logic [W-1:0]  hi_o, lo_o;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   lat;
  bit   saw_busy;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .op_i          (op_i),
    .opa_i         (opa_i),
    .opb_i         (opb_i),
    .annul_i       (annul_i),
    .busy_o        (busy_o),
    .ready_o       (ready_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .div_by_zero_o (div_by_zero_o)
  );

  always @(negedge clk) begin
    if (ready_o === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ready hi=%h lo=%h dbz=%b, no result expected", hi_o, lo_o, div_by_zero_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (hi_o !== e.hi || lo_o !== e.lo || div_by_zero_o !== e.dbz) begin
          n_err++;
          $display("FAIL result got hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
                   hi_o, lo_o, div_by_zero_o, e.hi, e.lo, e.dbz);
        end
      end
    end
  end

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    longint sa, sbv;
    logic [63:0] p, q, m;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    r.dbz = 1'b0;
    p = '0; q = '0; m = '0;
    case (op)
      2'b00: p = {32'b0, a} * {32'b0, b};
      2'b01: p = sa * sbv;
      default: begin
        if (b == '0) begin
          r.dbz = 1'b1;
          q = {32'b0, {W{1'b1}}};
          m = {32'b0, a};
        end else if (op == 2'b10) begin
          q = {32'b0, a} / {32'b0, b};
          m = {32'b0, a} % {32'b0, b};
        end else begin
          q = sa / sbv;
          m = sa % sbv;
        end
        p = {m[31:0], q[31:0]};
      end
    endcase
    r.hi = p[63:32];
    r.lo = p[31:0];
    return r;
  endfunction

  task automatic push(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dbz);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dbz = dbz;
    sb.push_back(e);
  endtask

  // Drives one start pulse and waits (bounded) for ready_o; lat counts cycles after the start edge.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op_i = op; opa_i = a; opb_i = b; start_i = 1'b1;
    lat = 0; saw_busy = 1'b0;
    repeat (100) begin
      @(negedge clk);
      start_i = 1'b0;
      lat++;
      if (busy_o) saw_busy = 1'b1;
      if (ready_o) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy_o, ready_o, hi_o, lo_o, div_by_zero_o} !== '0) begin
      n_err++;
      $display("FAIL reset busy=%b ready=%b hi=%h lo=%h dbz=%b, want all 0", busy_o, ready_o, hi_o, lo_o, div_by_zero_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul;
    push(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op(2'b01, 32'hFFFFFFFF, 32'h00000002);
    n_vec++;
    if (lat !== W+2) begin n_err++; $display("FAIL mult_latency got %0d want %0d", lat, W+2); end
    push(32'h00000001, 32'hFFFFFFFE, 1'b0);
    run_op(2'b00, 32'hFFFFFFFF, 32'h00000002);
    n_vec++;
    if (lat !== W+2) begin n_err++; $display("FAIL multu_latency got %0d want %0d", lat, W+2); end
  endtask

  task automatic test_div;
    push(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op(2'b11, 32'hFFFFFFF9, 32'h2);
    push(32'h1, 32'h3, 1'b0);
    run_op(2'b10, 32'h7, 32'h2);
    n_vec++;
    if (lat !== W+2) begin n_err++; $display("FAIL divu_latency got %0d want %0d", lat, W+2); end
    push(32'h0, 32'h80000000, 1'b0);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF);
  endtask

  task automatic test_div_zero;
    push(32'h5, 32'hFFFFFFFF, 1'b1);
    run_op(2'b10, 32'h5, 32'h0);
    n_vec++;
    if (lat !== 1 || saw_busy !== 1'b0) begin
      n_err++;
      $display("FAIL div0_timing got lat=%0d busy_seen=%b want lat=1 busy_seen=0", lat, saw_busy);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (div_by_zero_o !== 1'b1) begin n_err++; $display("FAIL div0_hold got dbz=%b want 1", div_by_zero_o); end
    push(32'h0, 32'h6, 1'b0);
    run_op(2'b00, 32'h2, 32'h3);
  endtask

  task automatic test_annul;
    bit rdy_seen, busy_mid;
    push(32'h1, 32'h2, 1'b0);
    run_op(2'b10, 32'h7, 32'h3);
    @(negedge clk);
    op_i = 2'b01; opa_i = 32'h12345; opb_i = 32'hFFFF0001; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    busy_mid = busy_o;
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    n_vec++;
    if (busy_mid !== 1'b1 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL annul_busy got before=%b after=%b want 1/0", busy_mid, busy_o);
    end
    rdy_seen = 1'b0;
    repeat (W+6) begin
      @(negedge clk);
      if (ready_o) rdy_seen = 1'b1;
    end
    n_vec++;
    if (rdy_seen || hi_o !== 32'h1 || lo_o !== 32'h2) begin
      n_err++;
      $display("FAIL annul_hold got ready_seen=%b hi=%h lo=%h want 0/1/2", rdy_seen, hi_o, lo_o);
    end
  endtask

  task automatic test_start_annul;
    bit act;
    @(negedge clk);
    op_i = 2'b10; opa_i = 32'h9; opb_i = 32'h0; start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    act = busy_o | ready_o;
    repeat (4) begin
      @(negedge clk);
      act |= busy_o | ready_o;
    end
    n_vec++;
    if (act !== 1'b0 || div_by_zero_o !== 1'b0) begin
      n_err++;
      $display("FAIL start_annul got activity=%b dbz=%b want 0/0", act, div_by_zero_o);
    end
  endtask

  task automatic test_rst_mid;
    @(negedge clk);
    op_i = 2'b11; opa_i = 32'h1000; opb_i = 32'h3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({busy_o, ready_o, hi_o, lo_o, div_by_zero_o} !== '0) begin
      n_err++;
      $display("FAIL rst_mid busy=%b ready=%b hi=%h lo=%h dbz=%b, want all 0", busy_o, ready_o, hi_o, lo_o, div_by_zero_o);
    end
    push(32'h2, 32'd14, 1'b0);
    run_op(2'b10, 32'd100, 32'd7);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a, b;
    logic [1:0]   op;
    exp_t e;
    logic [W-1:0] edge_vals [6];
    edge_vals[0] = 32'h80000000; edge_vals[1] = 32'hFFFFFFFF; edge_vals[2] = 32'h7FFFFFFF;
    edge_vals[3] = 32'h1;        edge_vals[4] = 32'h0;        edge_vals[5] = 32'hFFFFFFFE;
    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = (i % 3 == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      b  = (i % 4 == 1) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      e  = model(op, a, b);
      sb.push_back(e);
      run_op(op, a, b);
      n_vec++;
      if (lat !== ((op[1] && b == '0) ? 1 : W+2)) begin
        n_err++;
        $display("FAIL b2b_latency op=%0d a=%h b=%h got %0d", op, a, b, lat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_div_zero;
    test_annul;
    test_start_annul;
    test_rst_mid;
    test_back_to_back;
    repeat (3) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL pending_results got %0d outstanding want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the EX stage, covering MULT, MULTU, DIV and DIVU at a configurable operand width. It replaces the separate multiplier and divider with one FSM-driven datapath that shares a start/ready handshake. It supports annul (flush), divide-by-zero detection and sign correction. EX holds its stall request while `busy_o` is high, and writes `hi_o`/`lo_o` into HI/LO on `ready_o`.

## Interface
- WIDTH, 32, operand width in bits; must be ≥ 4 and even.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  request a new operation; sampled only in IDLE.
- op_i  in  2  operation code: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- opa_i  in  WIDTH  multiplicand or dividend.
- opb_i  in  WIDTH  multiplier or divisor.
- annul_i  in  1  abort any in-flight operation.
- busy_o  out  1  high in MUL, DIV and FIX states.
- ready_o  out  1  one-cycle pulse in DONE; `hi_o`/`lo_o` are valid from this cycle onward.
- hi_o  out  WIDTH  product high half, or remainder.
- lo_o  out  WIDTH  product low half, or quotient.
- div_by_zero_o  out  1  high with `ready_o` when a DIV/DIVU divisor was 0; holds until the next accepted start.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- **IDLE**, `start_i`=1 and `annul_i`=0:
  - latch `op_i` and the operands;
  - signed ops (MULT/DIV) latch absolute values plus neg_res (product or quotient sign) and neg_rem (sign of opa);
  - clear the counter;
  - next state is MUL or DIV;
  - exception: DIV/DIVU with `opb_i`==0 goes straight to DONE with hi=opa_i (raw), lo=all-ones, `div_by_zero_o`=1.
- **MUL**: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator. After WIDTH iterations, go to FIX.
- **DIV**: restoring division, one quotient bit per cycle. Remainder register is WIDTH+1 bits wide. After WIDTH iterations, go to FIX.
- **FIX**:
  - MULT: negate the 2·WIDTH product if neg_res.
  - DIV: negate the quotient if neg_res; negate the remainder if neg_rem.
  - Write `hi_o`/`lo_o`, then go to DONE.
- **DONE**: `ready_o`=1 for exactly one cycle, then go to IDLE unconditionally. `start_i` is ignored in DONE.
- Arithmetic rules:
  - All arithmetic is mod 2^WIDTH per half.
  - DIV of INT_MIN by −1 yields lo=INT_MIN, hi=0, with no flag.
  - Remainder sign follows the dividend.
- **annul_i**: in any non-IDLE state, the FSM returns to IDLE on the next edge. No `ready_o` is generated and `hi_o`/`lo_o`/`div_by_zero_o` keep their previous values. If `annul_i` and `start_i` are both high in IDLE, `annul_i` wins and nothing starts.
- `hi_o`/`lo_o` change only on entry to DONE. They hold until the next completion.

## Timing
- Reset: state IDLE, counter 0, `busy_o`=0, `ready_o`=0, `hi_o`=0, `lo_o`=0, `div_by_zero_o`=0.
- `rst` mid-operation aborts immediately to the reset values.
- Normal latency (start sampled at edge k):
  - MUL/DIV occupy cycles k+1 … k+WIDTH;
  - FIX occupies cycle k+WIDTH+1;
  - DONE (`ready_o`=1) occupies cycle k+WIDTH+2;
  - the next start can be accepted in cycle k+WIDTH+3.
- Divide by zero: DONE in cycle k+1 (latency 1). `busy_o` stays 0 throughout.
- `busy_o` is a registered decode of the state with no combinational path from the inputs. `ready_o` is likewise a state decode.
- Back-to-back throughput: one operation per WIDTH+3 cycles.

## Structure
- Shared defines package holds the MDU_OP_MULTU/MULT/DIVU/DIV encodings and the FSM state encodings (3 bits). The EX decode uses the same op encodings.
- Sub-module `mdu_div_step` is purely combinational: one restoring step taking {rem, dividend bit, divisor} and producing {new rem, q bit}. It is reusable if a radix-4 variant instantiates it twice per cycle.
- All remaining logic lives in one FSM and datapath: accumulator, counter, sign flags and output registers.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 → `ready_o` at edge k+34; hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) by 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 by 2 → lo=3, hi=1.
- DIV 0x80000000 by 0xFFFFFFFF → lo=0x80000000, hi=0, `div_by_zero_o`=0.
- DIVU 5 by 0 → `ready_o` in cycle k+1, `div_by_zero_o`=1, lo=0xFFFFFFFF, hi=5, `busy_o` never high.
- Abort paths:
  - after one result (hi=1, lo=2), start MULT, then assert `annul_i` at iteration 10 → `busy_o`=0 next cycle, no `ready_o`, hi/lo stay 1/2;
  - `start_i` together with `annul_i` in IDLE → nothing starts.
- `rst` asserted mid-DIV → all outputs 0 next cycle. A new DIVU 100 by 7 then completes with lo=14, hi=2.
